bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter M, default 4, number of requesters sharing one tri-state bus (M >= 2).
REQ-002 SHALL have parameter HOLD_MAX, default 8, maximum consecutive cycles one owner keeps the bus (HOLD_MAX >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  M  per-requester bus request, level-sensitive, held high while bus wanted.
REQ-006 SHALL have port en  output  M  per-requester buffer control (drives each buffer's control input); one-hot or all-zero.
REQ-007 SHALL have port grant_id  output  clog2(M)  index of current owner; valid only while en != 0.
REQ-008 SHALL have port busy  output  1  high whenever the arbiter is not in IDLE.

Function
REQ-009 SHALL implement states IDLE, GRANT, TURN; en, grant_id, busy all registered (no combinational path from req to any output).
REQ-010 SHALL never assert more than one en bit in any cycle.
REQ-011 SHALL, in IDLE with req != 0 at a rising edge, go to GRANT and set en to the selected requester's one-hot on that same edge (1-cycle latency from sampled req to en).
REQ-012 SHALL select round-robin: search starts at index ptr, ascending, wrapping M-1 -> 0; first requester found wins.
REQ-013 SHALL hold ptr = 0 after reset and set ptr = (owner + 1) mod M on every exit from GRANT.
REQ-014 SHALL keep a hold counter, width clog2(HOLD_MAX+1), cleared on entry to GRANT, incremented each cycle in GRANT.
REQ-015 SHALL leave GRANT for TURN when req[owner] is sampled low, or when the hold counter reaches HOLD_MAX (forced release), whichever comes first.
REQ-016 SHALL drive en = 0 for exactly one cycle in TURN (bus turnaround; no two drivers adjacent).
REQ-017 SHALL, at the end of TURN, arbitrate as in IDLE: req != 0 -> GRANT with new owner, else IDLE.
REQ-018 SHALL let a forcibly released owner still holding req compete again at lowest priority via ptr rotation; if it is the only requester it is re-granted after the TURN cycle.
REQ-019 SHALL ignore req changes of non-owners during GRANT.
REQ-020 SHALL hold grant_id at its last value when en = 0.
REQ-021 SHALL treat req[owner] falling and hold counter reaching HOLD_MAX in the same cycle as one release (single TURN, ptr updated once).
REQ-022 SHALL set busy = 1 in GRANT and TURN, 0 in IDLE.

Reset
REQ-023 SHALL, while rst_n = 0, force en = 0, grant_id = 0, busy = 0, ptr = 0, hold counter = 0, state IDLE, immediately and independent of clk.
REQ-024 SHALL, on reset asserted mid-GRANT, drop en to 0 without waiting for a clock edge; first grant after release follows REQ-011 with ptr = 0.
REQ-025 SHALL sample req no earlier than the first rising edge after rst_n deasserts.

Verification (M = 4, HOLD_MAX = 4)
REQ-026 SHALL cover: reset, req = 0000 for 5 cycles -> en = 0000, busy = 0 throughout.
REQ-027 SHALL cover: req = 0100 held 2 cycles then 0000 -> en = 0100 for 2 cycles, en = 0000 one TURN cycle, then IDLE, busy = 0.
REQ-028 SHALL cover: req = 1111 held continuously -> grants 0001, 0010, 0100, 1000, 0001 each exactly 4 cycles, each separated by one en = 0000 cycle, grant_id 0,1,2,3,0.
REQ-029 SHALL cover: req = 0001 held alone 10 cycles -> en = 0001 4 cycles, 0000 1 cycle, 0001 4 cycles (forced release and re-grant).
REQ-030 SHALL cover: during grant to index 2, rst_n pulsed low mid-cycle -> en = 0000 before the next edge; after release with req = 1111 first grant is 0001.
REQ-031 SHALL, every cycle, check en is one-hot or zero and that no two different owners are granted on adjacent cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with forced release
// after HOLD_MAX cycles and a one-cycle turnaround between drivers.
module bus_arbiter #(
  parameter int M        = 4,
  parameter int HOLD_MAX = 8,
  localparam int IW = (M > 1) ? $clog2(M) : 1,
  localparam int CW = $clog2(HOLD_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [M-1:0]  req,
  output logic [M-1:0]  en,
  output logic [IW-1:0] grant_id,
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] nxt_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          found;
  logic          rel;
  int            k;

  // First requester at or after ptr, wrapping past M-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int i = 0; i < M; i++) begin
      k = int'(ptr) + i;
      if (k >= M) k = k - M;
      if (!found && req[k]) begin
        found = 1'b1;
        win   = k[IW-1:0];
      end
    end
  end

  assign cnt_inc = cnt + CW'(1);
  assign rel     = !req[grant_id] ||
                   (cnt_inc == CW'(HOLD_MAX));
  assign nxt_ptr = (grant_id == IW'(M - 1)) ?
                   '0 : grant_id + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      en       <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE, TURN: begin
          if (found) begin
            state    <= GRANT;
            en       <= ONE << win;
            grant_id <= win;
            cnt      <= '0;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
            en    <= '0;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          cnt <= cnt_inc;
          if (rel) begin
            state <= TURN;
            en    <= '0;
            ptr   <= nxt_ptr;
          end
        end
        default: begin
          state <= IDLE;
          en    <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter (M=4, HOLD_MAX=4)
// against a tenure-counting ownership model.
module tb_bus_arbiter;

  localparam int M    = 4;
  localparam int HOLD = 4;

  typedef struct packed {
    logic [3:0] en;
    logic [1:0] gid;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] en;
  logic [1:0] grant_id;
  logic       busy;

  int checks;
  int failures;

  exp_t q[$];

  int m_owner;
  int m_ptr;
  int m_gid;
  int m_ten;
  bit m_turn;

  bus_arbiter #(.M(M), .HOLD_MAX(HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .en(en),
    .grant_id(grant_id),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_gid   = 0;
    m_ten   = 0;
    m_turn  = 0;
  endtask

  // One rising edge of ownership rules applied to sampled r.
  task automatic model_edge(input logic [3:0] r);
    exp_t e;
    int   pick;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_ten == HOLD) begin
        m_ptr   = (m_owner + 1) % M;
        m_owner = -1;
        m_turn  = 1;
      end else begin
        m_ten++;
      end
    end else begin
      m_turn = 0;
      pick = -1;
      for (int i = 0; i < M; i++)
        if (pick < 0 && r[(m_ptr + i) % M])
          pick = (m_ptr + i) % M;
      if (pick >= 0) begin
        m_owner = pick;
        m_gid   = pick;
        m_ten   = 1;
      end
    end
    e.en   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    e.gid  = 2'(m_gid);
    e.busy = (m_owner >= 0) || m_turn;
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_edge(r);
  endtask

  logic [3:0] prev_en;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      prev_en = '0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      check("en", int'(en), int'(e.en));
      check("grant_id", int'(grant_id), int'(e.gid));
      check("busy", int'(busy), int'(e.busy));
      check("onehot0", int'($onehot0(en)), 1);
      check("adjacent",
            int'(prev_en != 0 && en != 0 &&
                 prev_en != en), 0);
      prev_en = en;
    end
  end

  initial begin
    logic [3:0] r;
    checks   = 0;
    failures = 0;
    prev_en  = '0;
    model_reset();
    rst_n = 1'b0;
    req   = '0;
    #2;
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gid", int'(grant_id), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    repeat (5) step(4'b0000);
    repeat (2) step(4'b0100);
    repeat (3) step(4'b0000);
    repeat (24) step(4'b1111);
    repeat (2) step(4'b0000);
    repeat (10) step(4'b0001);
    repeat (3) step(4'b0000);

    // Model ptr is now 1; fresh reset so req=0100 grants index 2.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(4'b0100);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_en", int'(en), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_gid", int'(grant_id), 0);
    model_reset();
    @(negedge clk);
    req   = 4'b1111;
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(4'b1111);
    #1;
    check("first_after_rst", int'(en), 1);
    repeat (6) step(4'b1111);

    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0)
        r = 4'($urandom_range(15));
      step(r);
    end
    repeat (3) step(4'b0000);
    @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

endmodule
